gate_check_sequencer: RTL and testbench
=======================================

# gate_check_sequencer

Self-checking stimulus sequencer for a single-output combinational gate under test (e.g. NOT_1x1, AND/OR variants). On `start` it walks every input vector, holds each for a settle window, compares the gate output against a parameterised truth table, and reports pass/fail with an error count and the first failing vector. It is the on-chip replacement for the hand-written `#100`-style stimulus benches in the lab gate modules.

## Interface
- `N_IN`, 1: number of gate inputs, 1..4.
- `TRUTH`, 2'b01: expected output, `TRUTH[v]` for input vector `v`; width `2**N_IN`. Default is the NOT truth table.
- `SETTLE`, 4: wait cycles between applying a vector and checking it, 1..255.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  terminate the current run; sampled in all non-IDLE states.
- `dut_out`  in  1  output of the gate under test.
- `stim`  out  N_IN  registered input vector driven to the gate.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on completion of a full run.
- `pass`  out  1  high when the last completed run had zero errors.
- `err_count`  out  N_IN+1  mismatches in the current or last run.
- `fail_valid`  out  1  at least one mismatch recorded.
- `fail_vec`  out  N_IN  first vector that mismatched.

## Operation
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE: on `start`, go to APPLY; clear `vec`, `err_count`, `fail_valid`, `fail_vec`, `pass`.
- APPLY, one cycle: `stim <= vec`; load settle counter with SETTLE-1; go to WAIT.
- WAIT: counts down; at 0, go to CHECK. Lasts exactly SETTLE cycles.
- CHECK, one cycle: compare `dut_out` with `TRUTH[vec]`.
  - On mismatch, `err_count` increments. If `fail_valid` is 0, set it and load `fail_vec <= vec`.
  - If `vec == 2**N_IN-1`, go to DONE. Otherwise `vec` increments and the FSM goes to APPLY.
- DONE, one cycle: `done=1`; `pass <= (err_count==0)` (includes a mismatch found in the final CHECK); go to IDLE.
- `abort` in APPLY/WAIT/CHECK: go to IDLE next cycle.
  - `done` does not pulse and `pass` stays 0.
  - `err_count`, `fail_*` hold their values.
  - `stim` returns to 0.
- `abort` in DONE has no effect; DONE always completes.
- `start` while busy is ignored. `start` and `abort` together in IDLE: the run starts and `abort` is ignored.
- `err_count` cannot overflow (max `2**N_IN`), so no saturation logic.
- Results hold in IDLE until the next accepted `start`.

## Timing
- Reset values: state=IDLE, `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_vec`=0. Reset has priority over all inputs, including mid-run.
- `busy` rises the cycle after `start` is sampled.
- `stim` is visible SETTLE+1 cycles before its CHECK sample. `dut_out` is treated as combinational from `stim`.
- Per vector: SETTLE+2 cycles.
- Completion: `done` pulses 1 + 2**N_IN*(SETTLE+2) cycles after the `start` cycle. With the defaults this is 13 cycles.
- `pass` updates on the same edge that `done` rises. `busy` falls the cycle after `done`.

## Structure
- Shared include `gate_check_defs.vh` holds:
  - the state encoding localparams (3-bit);
  - the settle-counter width constant (8).
- One sub-module, `settle_timer`: loadable 8-bit down-counter with `load`, `value`, and `zero` outputs. Used by WAIT.
- Top level holds the FSM, the `vec` counter and the result registers.

## Test plan
- Defaults, gate is a correct NOT, one `start` pulse:
  - `stim` shows 0 then 1;
  - `done` at cycle 13;
  - `pass=1`, `err_count=0`, `fail_valid=0`.
- Defaults, gate replaced by a buffer: `done` at cycle 13, `pass=0`, `err_count=2`, `fail_valid=1`, `fail_vec=0`.
- `N_IN=2`, `TRUTH=4'b1000`, SETTLE=2, AND2 output stuck at 0:
  - `done` at cycle 17;
  - `err_count=1`, `fail_vec=3`, `pass=0`.
- Defaults, `abort` asserted in the second WAIT:
  - IDLE next cycle, no `done` pulse;
  - `pass=0`, `stim=0`.
  - A following `start` then completes with `pass=1`.
- `start` re-pulsed during WAIT: ignored; `done` still at cycle 13 from the original start.
- `rst` asserted during CHECK of vector 0 with a faulty gate: every output is at its reset value next cycle, and `err_count=0`.

Source files
------------

// File: rtl/gate_check_sequencer_pkg.sv
// gate_check_sequencer_pkg
//   Shared definitions for the gate check sequencer:
//   - state_e   : 3-bit FSM state encoding
//   - SETTLE_W  : width of the settle down-counter
package gate_check_sequencer_pkg;

    localparam int SETTLE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/gate_check_sequencer_settle_timer.sv
// settle_timer
//   Loadable down-counter that times the settle window after a new
//   stimulus vector is applied. It stops at zero rather than wrapping.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   load     : load `value` into the counter (wins over en)
//   value    : reload value
//   en       : decrement by one when non-zero
//   zero     : counter is at zero
module settle_timer
    import gate_check_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] value,
    input  logic                en,
    output logic                zero
);

    logic [SETTLE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_check_sequencer.sv
// gate_check_sequencer
//   Walks every input vector of a combinational gate, holds each for a
//   settle window, compares the gate output against TRUTH and reports
//   pass/fail, the mismatch count and the first failing vector.
// Parameters:
//   N_IN   : gate input count (1..4)
//   TRUTH  : expected output, TRUTH[v] for input vector v
//   SETTLE : cycles between applying a vector and checking it (1..255)
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a run (IDLE only)
//   abort      : stop the current run (any busy state except DONE)
//   dut_out    : output of the gate under test
//   stim       : registered input vector to the gate
//   busy       : not in IDLE
//   done       : one-cycle pulse when a full run completes
//   pass       : last completed run had zero mismatches
//   err_count  : mismatches in the current or last run
//   fail_valid : at least one mismatch recorded
//   fail_vec   : first mismatching vector
module gate_check_sequencer
    import gate_check_sequencer_pkg::*;
#(
    parameter int                   N_IN   = 1,
    parameter logic [2**N_IN-1:0]   TRUTH  = 2'b01,
    parameter int                   SETTLE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_out,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);

    localparam logic [N_IN-1:0]     VEC_LAST   = '1;
    localparam logic [SETTLE_W-1:0] SETTLE_LD  = SETTLE_W'(SETTLE - 1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [N_IN:0]   err_q, err_d;
    logic            fv_q, fv_d;
    logic [N_IN-1:0] fvec_q, fvec_d;
    logic            pass_q, pass_d;
    logic            done_q, done_d;
    logic            tmr_load, tmr_en, tmr_zero;

    settle_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (SETTLE_LD),
        .en    (tmr_en),
        .zero  (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        stim_d   = stim_q;
        err_d    = err_q;
        fv_d     = fv_q;
        fvec_d   = fvec_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous abort
                if (start) begin
                    state_d = ST_APPLY;
                    vec_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fvec_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    stim_d  = '0;
                end else begin
                    stim_d   = vec_q;
                    tmr_load = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    stim_d  = '0;
                end else if (tmr_zero) begin
                    state_d = ST_CHECK;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_CHECK: begin
                // an aborted CHECK records nothing
                if (abort) begin
                    state_d = ST_IDLE;
                    stim_d  = '0;
                end else begin
                    if (dut_out != TRUTH[vec_q]) begin
                        err_d = err_q + 1'b1;
                        if (!fv_q) begin
                            fv_d   = 1'b1;
                            fvec_d = vec_q;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        // done/pass register on the edge into DONE so the
                        // verdict includes this final comparison
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d   = vec_q + 1'b1;
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            stim_q  <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    assign stim       = stim_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_check_sequencer.sv
// tb_gate_check_sequencer
//   u0: defaults (NOT gate, or buffer when bad0=1).
//   u1: N_IN=2, TRUTH=4'b1000, SETTLE=2, AND2 stuck at 0.
//   Cycle k counts negedges after the negedge that raised start (cycle 0).
module tb_gate_check_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, abort0, bad0, start1, abort1;
    logic [0:0] stim0, fvec0;
    logic [1:0] err0;
    logic       busy0, done0, pass0, fv0, dut_out0;
    logic [1:0] stim1, fvec1;
    logic [2:0] err1;
    logic       busy1, done1, pass1, fv1, dut_out1;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign dut_out0 = bad0 ? stim0[0] : ~stim0[0];
    assign dut_out1 = 1'b0;

    gate_check_sequencer u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .dut_out(dut_out0),
        .stim(stim0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_valid(fv0), .fail_vec(fvec0)
    );

    gate_check_sequencer #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .dut_out(dut_out1),
        .stim(stim1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1)
    );

    typedef struct {
        int   inst;
        logic bad;
        int   exp_cyc;
        int   exp_pass;
        int   exp_err;
        int   exp_fv;
        int   exp_fvec;
    } run_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One full run on instance r.inst; checks latency and results.
    task automatic run_one(input run_t r);
        int got;
        bad0 = r.bad;
        @(negedge clk);
        if (r.inst == 0) start0 = 1'b1; else start1 = 1'b1;
        got = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start0 = 1'b0;
                start1 = 1'b0;
                chk("busy_rise", (r.inst == 0) ? busy0 : busy1, 1);
            end
            if (r.inst == 0 && k == 2) chk("stim_vec0", stim0, 0);
            if (r.inst == 0 && k == 8) chk("stim_vec1", stim0, 1);
            if ((r.inst == 0) ? done0 : done1) begin
                got = k;
                break;
            end
        end
        chk("done_cycle", got, r.exp_cyc);
        if (r.inst == 0) begin
            chk("pass", pass0, r.exp_pass);
            chk("err_count", err0, r.exp_err);
            chk("fail_valid", fv0, r.exp_fv);
            chk("fail_vec", fvec0, r.exp_fvec);
        end else begin
            chk("pass", pass1, r.exp_pass);
            chk("err_count", err1, r.exp_err);
            chk("fail_valid", fv1, r.exp_fv);
            chk("fail_vec", fvec1, r.exp_fvec);
        end
        @(negedge clk);
        chk("busy_fall", (r.inst == 0) ? busy0 : busy1, 0);
        chk("done_pulse_len", (r.inst == 0) ? done0 : done1, 0);
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_stim"},  stim0, 0);
        chk({tag, "_busy"},  busy0, 0);
        chk({tag, "_done"},  done0, 0);
        chk({tag, "_pass"},  pass0, 0);
        chk({tag, "_err"},   err0,  0);
        chk({tag, "_fv"},    fv0,   0);
        chk({tag, "_fvec"},  fvec0, 0);
    endtask

    run_t runs[4];

    initial begin
        int got;
        int ndone;

        runs[0] = '{0, 1'b0, 13, 1, 0, 0, 0};  // correct NOT
        runs[1] = '{0, 1'b1, 13, 0, 2, 1, 0};  // buffer instead of NOT
        runs[2] = '{1, 1'b0, 17, 0, 1, 1, 3};  // AND2 stuck at 0
        runs[3] = '{0, 1'b0, 13, 1, 0, 0, 0};  // recovers after a failing run

        rst = 1'b1; start0 = 1'b0; abort0 = 1'b0; bad0 = 1'b0;
        start1 = 1'b0; abort1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset0("reset");
        chk("reset_busy1", busy1, 0);
        chk("reset_err1", err1, 0);

        for (int i = 0; i < 4; i++) run_one(runs[i]);

        // abort in the second WAIT (vector 1 WAIT spans cycles 8..11)
        bad0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) start0 = 1'b0;
            if (k == 9) abort0 = 1'b1;
        end
        @(negedge clk);
        abort0 = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_stim", stim0, 0);
        chk("abort_pass", pass0, 0);
        chk("abort_err", err0, 0);
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_one('{0, 1'b0, 13, 1, 0, 0, 0});

        // start re-pulsed during WAIT of vector 0
        @(negedge clk);
        start0 = 1'b1;
        got = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start0 = (k == 4);
            if (done0) begin
                got = k;
                break;
            end
        end
        start0 = 1'b0;
        chk("restart_done_cycle", got, 13);
        chk("restart_pass", pass0, 1);
        repeat (2) @(negedge clk);

        // reset during CHECK of vector 0 (cycle 6) with a faulty gate
        bad0 = 1'b1;
        @(negedge clk);
        start0 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) start0 = 1'b0;
            if (k == 6) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk_reset0("midrst");
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done0 || busy0) ndone++;
        end
        chk("midrst_stays_idle", ndone, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
